// File: rtl/vedic_mul_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one (WIDTH/2)x(WIDTH/2) multiplier reused over four cycles.
// Define VEDIC_SIGNED_EN for two's-complement operands and product (sign-magnitude around the unsigned core).
module vedic_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic [2:0]           dbg_state_o
);
    localparam int H = WIDTH / 2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("vedic_mul_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    // Handshake: start is accepted only while busy=0; done pulses for one cycle with P updated.
    typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d, rb_q, rb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d;
    logic               done_q, done_d;
    logic               sgn_q, sgn_d;

    logic [H-1:0]       qa, qb;
    logic [WIDTH-1:0]   qprod;
    logic [2*WIDTH-1:0] qext, qterm, sum;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_sgn;

`ifdef VEDIC_SIGNED_EN
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;
    assign a_sgn = A[WIDTH-1] ^ B[WIDTH-1];
`else
    assign a_mag = A;
    assign b_mag = B;
    assign a_sgn = 1'b0;
`endif

    // Operand halves steered into the shared quarter multiplier by state.
    always_comb begin
        qa = '0;
        qb = '0;
        case (state_q)
            Q0: begin qa = ra_q[H-1:0];     qb = rb_q[H-1:0];     end
            Q1: begin qa = ra_q[H-1:0];     qb = rb_q[WIDTH-1:H]; end
            Q2: begin qa = ra_q[WIDTH-1:H]; qb = rb_q[H-1:0];     end
            Q3: begin qa = ra_q[WIDTH-1:H]; qb = rb_q[WIDTH-1:H]; end
            default: ;
        endcase
    end

    assign qprod = WIDTH'(qa) * WIDTH'(qb);
    assign qext  = {{WIDTH{1'b0}}, qprod};

    always_comb begin
        qterm = qext;
        case (state_q)
            Q1, Q2:  qterm = qext << H;
            Q3:      qterm = qext << WIDTH;
            default: qterm = qext;
        endcase
    end

    assign sum = acc_q + qterm;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        p_d     = p_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a_mag;
                    rb_d    = b_mag;
                    sgn_d   = a_sgn;
                    acc_d   = '0;
                    state_d = Q0;
                end
            end
            Q0: begin acc_d = sum; state_d = Q1; end
            Q1: begin acc_d = sum; state_d = Q2; end
            Q2: begin acc_d = sum; state_d = Q3; end
            Q3: begin
                p_d     = sgn_q ? -sum : sum;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign P           = p_q;
    assign dbg_state_o = state_q;
endmodule
